fa_bist_checker: RTL and testbench

FA_BIST_CHECKER -- requirements
Module: fa_bist_checker

---
 rtl/fa_bist_checker.sv | 202 ++++++++++++++++++++
 tb/tb_fa_bist_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fa_bist_checker.sv
// -----------------------------------------------------------------------------
// fa_bist_checker
//
// Built-in self-test sequencer for a single-bit full adder. On a start request
// it applies all eight input combinations {In_0,In_1,Cin} in ascending order.
// Each vector is held for SETTLE_CYCLES cycles and then sampled for one cycle.
// The sampled Sout/Cout are compared with the reference sum and carry. The
// block counts mismatches (saturating at 15), records the first failing
// vector, and reports pass/fail at the end of the run.
//
// Parameters
//   SETTLE_CYCLES  settle cycles per vector before sampling (1..15)
//
// Ports
//   clk         input   single clock; all state changes on its rising edge
//   rst         input   asynchronous active-high reset
//   start       input   one-cycle run request (honoured only in IDLE)
//   In_0        output  registered stimulus, vector bit 2
//   In_1        output  registered stimulus, vector bit 1
//   Cin         output  registered stimulus, vector bit 0
//   Sout        input   sum returned by the adder under test
//   Cout        input   carry returned by the adder under test
//   busy        output  high while in DRIVE or SAMPLE
//   done        output  one-cycle end-of-run pulse
//   pass        output  last run had zero mismatches
//   err_count   output  mismatch count of current/last run (saturates at 15)
//   fail_vec    output  first failing vector {In_0,In_1,Cin}
//   fail_valid  output  fail_vec holds a captured value
//
// Build option
//   FA_BIST_STOP_ON_FAIL_EN  when defined, the run ends at the first mismatch.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// DRIVE  | stimulus applied, settle counter running down
// SAMPLE | adder outputs compared against the reference
// DONE   | one-cycle done pulse, stimulus returned to 0
// -----------------------------------------------------------------------------
module fa_bist_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       In_0,
  output logic       In_1,
  output logic       Cin,
  input  logic       Sout,
  input  logic       Cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec,
  output logic       fail_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // The down-counter reaches zero on the last DRIVE cycle, so DRIVE lasts
  // exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_vec;
  logic [2:0] r_drive;
  logic [3:0] r_settle;
  logic [3:0] r_err_count;
  logic [2:0] r_fail_vec;
  logic       r_fail_valid;
  logic       r_pass;

  logic       w_busy;
  logic       w_done;
  logic       w_exp_sum;
  logic       w_exp_cout;
  logic       w_mismatch;
  logic       w_last;
  logic       w_stop;
  logic [3:0] w_err_nxt;

  assign w_exp_sum  = r_vec[2] ^ r_vec[1] ^ r_vec[0];
  assign w_exp_cout = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
  assign w_mismatch = (Sout != w_exp_sum) || (Cout != w_exp_cout);
  assign w_last     = (r_vec == 3'd7);
  assign w_err_nxt  = (w_mismatch && (r_err_count != 4'd15)) ? r_err_count + 4'd1 : r_err_count;

`ifdef FA_BIST_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        w_busy = 1'b1;
        if (r_settle == 4'd0) begin
          w_state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        w_busy = 1'b1;
        if (w_last || w_stop) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DRIVE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec        <= 3'd0;
      r_drive      <= 3'd0;
      r_settle     <= 4'd0;
      r_err_count  <= 4'd0;
      r_fail_vec   <= 3'd0;
      r_fail_valid <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vec        <= 3'd0;
            r_drive      <= 3'd0;
            r_settle     <= SETTLE_LOAD;
            r_err_count  <= 4'd0;
            r_fail_vec   <= 3'd0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
          end
        end
        DRIVE: begin
          if (r_settle != 4'd0) begin
            r_settle <= r_settle - 4'd1;
          end
        end
        SAMPLE: begin
          r_err_count <= w_err_nxt;
          if (w_mismatch && !r_fail_valid) begin
            r_fail_vec   <= r_vec;
            r_fail_valid <= 1'b1;
          end
          if (w_last || w_stop) begin
            // Pass is resolved on entry to DONE so it is already valid
            // during the done pulse.
            r_drive <= 3'd0;
            r_pass  <= (w_err_nxt == 4'd0);
          end else begin
            r_vec    <= r_vec + 3'd1;
            r_drive  <= r_vec + 3'd1;
            r_settle <= SETTLE_LOAD;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign In_0       = r_drive[2];
  assign In_1       = r_drive[1];
  assign Cin        = r_drive[0];
  assign busy       = w_busy;
  assign done       = w_done;
  assign pass       = r_pass;
  assign err_count  = r_err_count;
  assign fail_vec   = r_fail_vec;
  assign fail_valid = r_fail_valid;

endmodule

// File: tb/tb_fa_bist_checker.sv
module tb_fa_bist_checker;

  localparam int S = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       In_0, In_1, Cin;
  logic       Sout, Cout;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_vec;
  logic       fail_valid;
  logic [1:0] fault;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    int         done_c;
    logic [3:0] err;
    logic [2:0] fv;
    logic       fvalid;
    logic       pass;
  } exp_t;

  exp_t sb[$];

  fa_bist_checker #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .In_0       (In_0),
    .In_1       (In_1),
    .Cin        (Cin),
    .Sout       (Sout),
    .Cout       (Cout),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_vec   (fail_vec),
    .fail_valid (fail_valid)
  );

  // Adder under test with selectable fault: 0 good, 1 Cout stuck 0, 2 Sout inverted.
  always_comb begin
    Sout = In_0 ^ In_1 ^ Cin;
    Cout = (In_0 & In_1) | (In_0 & Cin) | (In_1 & Cin);
    if (fault == 2'd1) Cout = 1'b0;
    if (fault == 2'd2) Sout = ~(In_0 ^ In_1 ^ Cin);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] f);
    exp_t       e;
    int         k_end;
    logic [2:0] v;
    logic       s, c, ds, dc, mm;
    k_end    = 7;
    e.err    = 4'd0;
    e.fv     = 3'd0;
    e.fvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      v  = 3'(k);
      s  = ^v;
      c  = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      ds = (f == 2'd2) ? ~s : s;
      dc = (f == 2'd1) ? 1'b0 : c;
      mm = (ds != s) || (dc != c);
      if (mm) begin
        if (e.err != 4'd15) e.err = e.err + 4'd1;
        if (!e.fvalid) begin
          e.fv     = v;
          e.fvalid = 1'b1;
        end
      end
`ifdef FA_BIST_STOP_ON_FAIL_EN
      if (mm) begin
        k_end = k;
        break;
      end
`endif
    end
    e.pass   = (e.err == 4'd0);
    e.done_c = (k_end + 1) * (S + 1) + 1;
    return e;
  endfunction

  // Starts a run at the next rising edge (cycle 0) and checks every cycle
  // after it. glitch pulses start while busy and during the done cycle.
  // abort_at>0 asserts rst in that cycle and abandons the run.
  task automatic run_test(input string name, input logic [1:0] f, input bit glitch, input int abort_at);
    exp_t       e;
    exp_t       got;
    int         dc;
    bit         seen;
    logic       eb, ed;
    logic [2:0] ein;
    fault = f;
    e     = model(f);
    sb.push_back(e);
    dc    = e.done_c;
    seen  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= dc + 2; c++) begin
      @(negedge clk);
      eb  = (c >= 1) && (c < dc);
      ed  = (c == dc);
      ein = eb ? 3'((c - 1) / (S + 1)) : 3'd0;
      check({name, " timing"}, 16'({busy, done, In_0, In_1, Cin}), 16'({eb, ed, ein}));
      if (c == 1) begin
        check({name, " cleared"}, 16'({err_count, fail_valid, pass}), 16'd0);
      end
      if (done === 1'b1 && sb.size() > 0) begin
        got  = sb.pop_front();
        seen = 1'b1;
        check({name, " err_count"},  16'(err_count),  16'(got.err));
        check({name, " fail_vec"},   16'(fail_vec),   16'(got.fv));
        check({name, " fail_valid"}, 16'(fail_valid), 16'(got.fvalid));
        check({name, " pass"},       16'(pass),       16'(got.pass));
      end
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check({name, " reset zero"},
              16'({In_0, In_1, Cin, busy, done, pass, err_count, fail_vec, fail_valid}), 16'd0);
        @(posedge clk);
        #1;
        check({name, " reset held"},
              16'({In_0, In_1, Cin, busy, done, pass, err_count, fail_vec, fail_valid}), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        return;
      end
      start = glitch && (c == 4 || c == dc);
    end
    start = 1'b0;
    check({name, " done seen"}, 16'(seen), 16'd1);
    check({name, " held"}, 16'({err_count, fail_vec, fail_valid, pass}),
          16'({e.err, e.fv, e.fvalid, e.pass}));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fault = 2'd0;
    #1;
    check("reset async", 16'({In_0, In_1, Cin, busy, done, pass, err_count, fail_vec, fail_valid}), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    run_test("good",        2'd0, 1'b0, 0);
    run_test("cout_stuck0", 2'd1, 1'b0, 0);
    run_test("sout_inv",    2'd2, 1'b0, 0);
    run_test("sout_inv_2",  2'd2, 1'b0, 0);
    run_test("abort",       2'd0, 1'b0, 10);
    run_test("restart",     2'd0, 1'b1, 0);
    run_test("cout_glitch", 2'd1, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
